// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module : alu_ctrl_pkg
// Brief  : ALU control codes, RV32I opcode/funct3 constants and decode enums
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [3:0] ALUC_ADD   = 4'b0000;
    localparam logic [3:0] ALUC_SUB   = 4'b0100;
    localparam logic [3:0] ALUC_AND   = 4'b0001;
    localparam logic [3:0] ALUC_OR    = 4'b0101;
    localparam logic [3:0] ALUC_XOR   = 4'b0010;
    localparam logic [3:0] ALUC_PASSB = 4'b0110;
    localparam logic [3:0] ALUC_SLL   = 4'b0011;
    localparam logic [3:0] ALUC_SRL   = 4'b0111;
    localparam logic [3:0] ALUC_SRA   = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_LT   = 3'd2,
        WB_LTU  = 3'd3,
        WB_PC4  = 3'd4
    } wb_sel_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LT   = 4'd3,
        BR_GE   = 4'd4,
        BR_LTU  = 4'd5,
        BR_GEU  = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_kind_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// Module : alu_op_decode
// Brief  : Combinational RV32I decode to ALU control, operand selects and
//          writeback/branch classification
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] aluc_o,
    output logic       opsel_a_o,   // 0: rs1, 1: pc
    output logic       opsel_b_o,   // 0: rs2, 1: imm
    output wb_sel_e    wb_sel_o,
    output br_kind_e   br_kind_o,
    output logic       illegal_o
);

    always_comb begin
        aluc_o    = ALUC_ADD;
        opsel_a_o = 1'b0;
        opsel_b_o = 1'b0;
        wb_sel_o  = WB_NONE;
        br_kind_o = BR_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_OP, OPC_OP_IMM: begin
                opsel_b_o = (opcode_i == OPC_OP_IMM);
                wb_sel_o  = WB_ALU;
                case (funct3_i)
                    F3_ADD:  aluc_o = (opcode_i == OPC_OP && funct7b5_i) ? ALUC_SUB : ALUC_ADD;
                    F3_SLL: begin
                        aluc_o = ALUC_SLL;
                        if (opcode_i == OPC_OP_IMM && funct7b5_i) begin
                            illegal_o = 1'b1;
                            wb_sel_o  = WB_NONE;
                        end
                    end
                    F3_SLT: begin
                        aluc_o   = ALUC_SUB;
                        wb_sel_o = WB_LT;
                    end
                    F3_SLTU: begin
                        aluc_o   = ALUC_SUB;
                        wb_sel_o = WB_LTU;
                    end
                    F3_XOR:  aluc_o = ALUC_XOR;
                    F3_SR:   aluc_o = funct7b5_i ? ALUC_SRA : ALUC_SRL;
                    F3_OR:   aluc_o = ALUC_OR;
                    default: aluc_o = ALUC_AND;
                endcase
            end
            OPC_LUI: begin
                aluc_o    = ALUC_PASSB;
                opsel_b_o = 1'b1;
                wb_sel_o  = WB_ALU;
            end
            OPC_AUIPC: begin
                opsel_a_o = 1'b1;
                opsel_b_o = 1'b1;
                wb_sel_o  = WB_ALU;
            end
            OPC_JAL: begin
                opsel_a_o = 1'b1;
                opsel_b_o = 1'b1;
                wb_sel_o  = WB_PC4;
                br_kind_o = BR_JAL;
            end
            OPC_JALR: begin
                opsel_b_o = 1'b1;
                wb_sel_o  = WB_PC4;
                br_kind_o = BR_JALR;
            end
            OPC_BRANCH: begin
                aluc_o = ALUC_SUB;
                case (funct3_i)
                    F3_BEQ:  br_kind_o = BR_EQ;
                    F3_BNE:  br_kind_o = BR_NE;
                    F3_BLT:  br_kind_o = BR_LT;
                    F3_BGE:  br_kind_o = BR_GE;
                    F3_BLTU: br_kind_o = BR_LTU;
                    F3_BGEU: br_kind_o = BR_GEU;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Two-stage execute initiator: S1 issues operands to an external ALU,
//          S2 holds the post-processed writeback/redirect result
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_aluc,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    logic [3:0] w_aluc;
    logic       w_opsel_a;
    logic       w_opsel_b;
    wb_sel_e    w_wb_sel;
    br_kind_e   w_br_kind;
    logic       w_illegal;

    alu_op_decode u_dec (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .aluc_o     (w_aluc),
        .opsel_a_o  (w_opsel_a),
        .opsel_b_o  (w_opsel_b),
        .wb_sel_o   (w_wb_sel),
        .br_kind_o  (w_br_kind),
        .illegal_o  (w_illegal)
    );

    logic            s1_valid_q, s2_valid_q;
    logic [XLEN-1:0] s1_a_q, s1_b_q, s1_pc_q, s1_imm_q;
    logic [3:0]      s1_aluc_q;
    logic [4:0]      s1_rd_q;
    wb_sel_e         s1_wb_q;
    br_kind_e        s1_br_q;
    logic            s1_ill_q;

    logic [4:0]      s2_rd_q;
    logic            s2_we_q, s2_taken_q, s2_ill_q;
    logic [XLEN-1:0] s2_wdata_q, s2_target_q;

    logic w_adv, w_accept, w_xfer;
    assign w_adv    = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || w_adv;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_xfer   = s1_valid_q && w_adv && !flush;

    // Signed/unsigned less-than recovered from the subtract result and operand signs
    logic            w_lt, w_ltu, w_a_msb, w_b_msb;
    logic            s2_taken_d, s2_we_d;
    logic [XLEN-1:0] s2_wdata_d, s2_target_d, w_pc_plus_imm, w_pc_plus_4;

    assign w_a_msb       = s1_a_q[XLEN-1];
    assign w_b_msb       = s1_b_q[XLEN-1];
    assign w_lt          = (w_a_msb ^ w_b_msb) ? w_a_msb : alu_result[XLEN-1];
    assign w_ltu         = (w_a_msb ^ w_b_msb) ? w_b_msb : alu_result[XLEN-1];
    assign w_pc_plus_imm = s1_pc_q + s1_imm_q;
    assign w_pc_plus_4   = s1_pc_q + {{(XLEN-3){1'b0}}, 3'b100};

    always_comb begin
        case (s1_br_q)
            BR_EQ:   s2_taken_d = alu_zero;
            BR_NE:   s2_taken_d = !alu_zero;
            BR_LT:   s2_taken_d = w_lt;
            BR_GE:   s2_taken_d = !w_lt;
            BR_LTU:  s2_taken_d = w_ltu;
            BR_GEU:  s2_taken_d = !w_ltu;
            BR_JAL,
            BR_JALR: s2_taken_d = 1'b1;
            default: s2_taken_d = 1'b0;
        endcase
        s2_target_d = (s1_br_q == BR_JALR) ? (alu_result & ~{{(XLEN-1){1'b0}}, 1'b1})
                                           : w_pc_plus_imm;
        case (s1_wb_q)
            WB_ALU:  s2_wdata_d = alu_result;
            WB_LT:   s2_wdata_d = {{(XLEN-1){1'b0}}, w_lt};
            WB_LTU:  s2_wdata_d = {{(XLEN-1){1'b0}}, w_ltu};
            WB_PC4:  s2_wdata_d = w_pc_plus_4;
            default: s2_wdata_d = '0;
        endcase
        s2_we_d = !s1_ill_q && (s1_wb_q != WB_NONE) && (s1_rd_q != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_aluc_q   <= ALUC_ADD;
            s1_pc_q     <= RESET_PC;
            s1_imm_q    <= '0;
            s1_rd_q     <= '0;
            s1_wb_q     <= WB_NONE;
            s1_br_q     <= BR_NONE;
            s1_ill_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_rd_q     <= '0;
            s2_we_q     <= 1'b0;
            s2_wdata_q  <= '0;
            s2_taken_q  <= 1'b0;
            s2_target_q <= '0;
            s2_ill_q    <= 1'b0;
        end else begin
            if (flush)         s1_valid_q <= 1'b0;
            else if (w_accept) s1_valid_q <= 1'b1;
            else if (w_adv)    s1_valid_q <= 1'b0;

            if (w_accept) begin
                s1_a_q    <= w_opsel_a ? pc : rs1_val;
                s1_b_q    <= w_opsel_b ? imm : rs2_val;
                s1_aluc_q <= w_aluc;
                s1_pc_q   <= pc;
                s1_imm_q  <= imm;
                s1_rd_q   <= rd;
                s1_wb_q   <= w_wb_sel;
                s1_br_q   <= w_br_kind;
                s1_ill_q  <= w_illegal;
            end

            if (flush)      s2_valid_q <= 1'b0;
            else if (w_adv) s2_valid_q <= s1_valid_q;

            if (w_xfer) begin
                s2_rd_q     <= s1_rd_q;
                s2_we_q     <= s2_we_d;
                s2_wdata_q  <= s2_wdata_d;
                s2_taken_q  <= s2_taken_d;
                s2_target_q <= s2_target_d;
                s2_ill_q    <= s1_ill_q;
            end
        end
    end

    assign alu_a        = s1_a_q;
    assign alu_b        = s1_b_q;
    assign alu_aluc     = s1_aluc_q;
    assign out_valid    = s2_valid_q;
    assign out_rd       = s2_rd_q;
    assign out_we       = s2_we_q;
    assign out_wdata    = s2_wdata_q;
    assign out_br_taken = s2_taken_q;
    assign out_target   = s2_target_q;
    assign out_illegal  = s2_ill_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Self-checking bench for alu_issue_ctrl with a behavioural ALU
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, funct7b5, out_valid, out_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, out_rd;
    logic [31:0] rs1_val, rs2_val, imm, pc, alu_a, alu_b, alu_result, out_wdata, out_target;
    logic [3:0]  alu_aluc;
    logic        alu_zero, out_we, out_br_taken, out_illegal;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .rd(rd),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_we(out_we),
        .out_wdata(out_wdata), .out_br_taken(out_br_taken), .out_target(out_target),
        .out_illegal(out_illegal)
    );

    always_comb begin
        alu_result = 32'h0;
        case (alu_aluc)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a - alu_b;
            4'b0001: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a ^ alu_b;
            4'b0110: alu_result = alu_b;
            4'b0011: alu_result = alu_a << alu_b[4:0];
            4'b0111: alu_result = alu_a >> alu_b[4:0];
            4'b1111: alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [31:0] rs1, rs2, imm, pc;
        logic        e_we;
        logic [31:0] e_wd;
        logic        c_wd;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        c_tgt;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [4:0] d,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] p);
        opcode = o; funct3 = f3; funct7b5 = f7; rd = d;
        rs1_val = r1; rs2_val = r2; imm = im; pc = p;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        drive(v.opc, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm, v.pc);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_valid", idx), {31'b0, out_valid}, 32'd1);
        check($sformatf("v%0d_we", idx), {31'b0, out_we}, {31'b0, v.e_we});
        check($sformatf("v%0d_illegal", idx), {31'b0, out_illegal}, {31'b0, v.e_ill});
        check($sformatf("v%0d_taken", idx), {31'b0, out_br_taken}, {31'b0, v.e_tk});
        if (v.c_wd) check($sformatf("v%0d_wdata", idx), out_wdata, v.e_wd);
        if (v.c_tgt) check($sformatf("v%0d_target", idx), out_target, v.e_tgt);
        if (v.e_we) check($sformatf("v%0d_rd", idx), {27'b0, out_rd}, {27'b0, v.rd});
    endtask

    initial begin
        int got[$];
        int idx, saw;
        logic rdy;

        //           opc        f3      f7    rd     rs1           rs2           imm           pc            we    wdata         cwd   tk    target        ctg   ill
        vecs.push_back(vec_t'{OPI,        3'b000, 1'b0, 5'd3,  32'd5,        32'd0,        32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b010, 1'b0, 5'd4,  32'h80000000, 32'd1,        32'd0,        32'd0,        1'b1, 32'd1,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b011, 1'b0, 5'd4,  32'h80000000, 32'd1,        32'd0,        32'd0,        1'b1, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b100, 1'b0, 5'd5,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      1'b0, 32'd0,        1'b0, 1'b1, 32'h120,      1'b1, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b101, 1'b0, 5'd5,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{7'b0000011, 3'b010, 1'b0, 5'd6,  32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b1});
        vecs.push_back(vec_t'{OP,         3'b000, 1'b0, 5'd0,  32'd3,        32'd4,        32'd0,        32'd0,        1'b0, 32'd7,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{7'b1100111, 3'b000, 1'b0, 5'd1,  32'h1001,     32'd0,        32'd4,        32'h40,       1'b1, 32'h44,       1'b1, 1'b1, 32'h1004,     1'b1, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b000, 1'b1, 5'd7,  32'd10,       32'd3,        32'd0,        32'd0,        1'b1, 32'd7,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OPI,        3'b101, 1'b1, 5'd8,  32'h80000000, 32'd0,        32'h404,      32'd0,        1'b1, 32'hF8000000, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OPI,        3'b101, 1'b0, 5'd8,  32'h80000000, 32'd0,        32'h4,        32'd0,        1'b1, 32'h08000000, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OPI,        3'b001, 1'b1, 5'd9,  32'd1,        32'd0,        32'h401,      32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b1});
        vecs.push_back(vec_t'{7'b0110111, 3'b000, 1'b0, 5'd10, 32'hDEADBEEF, 32'd0,        32'h12345000, 32'd0,        1'b1, 32'h12345000, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{7'b0010111, 3'b000, 1'b0, 5'd11, 32'd0,        32'd0,        32'h2000,     32'h1000,     1'b1, 32'h3000,     1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{7'b1101111, 3'b000, 1'b0, 5'd1,  32'd0,        32'd0,        32'h40,       32'h200,      1'b1, 32'h204,      1'b1, 1'b1, 32'h240,      1'b1, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b000, 1'b0, 5'd0,  32'd9,        32'd9,        32'hFFFFFFF8, 32'h300,      1'b0, 32'd0,        1'b0, 1'b1, 32'h2F8,      1'b1, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b001, 1'b0, 5'd0,  32'd9,        32'd9,        32'hFFFFFFF8, 32'h300,      1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b110, 1'b0, 5'd0,  32'd1,        32'hFFFFFFFF, 32'h10,       32'h10,       1'b0, 32'd0,        1'b0, 1'b1, 32'h20,       1'b1, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b111, 1'b0, 5'd0,  32'd1,        32'hFFFFFFFF, 32'h10,       32'h10,       1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{BR,         3'b010, 1'b0, 5'd0,  32'd1,        32'd1,        32'h10,       32'h10,       1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b1});
        vecs.push_back(vec_t'{OPI,        3'b100, 1'b0, 5'd12, 32'hF0F0,     32'd0,        32'hFF,       32'd0,        1'b1, 32'hF00F,     1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b110, 1'b0, 5'd13, 32'hF0,       32'h0F,       32'd0,        32'd0,        1'b1, 32'hFF,       1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b111, 1'b0, 5'd14, 32'hFF,       32'h0F,       32'd0,        32'd0,        1'b1, 32'h0F,       1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b001, 1'b0, 5'd15, 32'd1,        32'd31,       32'd0,        32'd0,        1'b1, 32'h80000000, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OPI,        3'b010, 1'b0, 5'd16, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFD, 32'd0,        1'b1, 32'd1,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OPI,        3'b011, 1'b0, 5'd17, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,        1'b1, 32'd1,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OP,         3'b101, 1'b1, 5'd18, 32'hFFFFFF00, 32'd4,        32'd0,        32'd0,        1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});
        vecs.push_back(vec_t'{OPI,        3'b000, 1'b1, 5'd19, 32'd5,        32'd0,        32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0});

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(7'd0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_we", {31'b0, out_we}, 32'd0);
        check("reset_out_wdata", out_wdata, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_aluc", {28'b0, alu_aluc}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        // Exact latency of ADDI, with the issued ALU operands visible from S1
        @(negedge clk);
        drive(OPI, 3'b000, 1'b0, 5'd3, 32'd5, 32'd0, 32'hFFFFFFF9, 32'd0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("addi_s1_no_out", {31'b0, out_valid}, 32'd0);
        check("addi_alu_aluc", {28'b0, alu_aluc}, 32'd0);
        check("addi_alu_a", alu_a, 32'd5);
        check("addi_alu_b", alu_b, 32'hFFFFFFF9);
        @(negedge clk);
        check("addi_out_valid", {31'b0, out_valid}, 32'd1);
        check("addi_out_wdata", out_wdata, 32'hFFFFFFFE);
        check("addi_out_we", {31'b0, out_we}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Stall: three back-to-back inputs while the consumer is held off
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (idx < 3) begin
                drive(OPI, 3'b000, 1'b0, 5'(idx + 1), 32'(idx + 1), 32'd0, 32'd0, 32'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            rdy = in_ready;
            if (out_valid && out_ready) got.push_back(int'(out_wdata));
            if (cyc == 2) begin
                check("stall_in_ready_low", {31'b0, in_ready}, 32'd0);
                check("stall_accepted", 32'(idx), 32'd2);
                check("stall_s2_wdata", out_wdata, 32'd1);
            end
            if (cyc == 3) check("stall_hold_wdata", out_wdata, 32'd1);
            @(posedge clk);
            if (in_valid && rdy) idx++;
        end
        check("stall_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("stall_order%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFFFFFF, 32'(k + 1));

        // Flush with both stages full and a same-cycle input
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        drive(OPI, 3'b000, 1'b0, 5'd1, 32'h11, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(OPI, 3'b000, 1'b0, 5'd2, 32'h22, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b1;
        drive(OPI, 3'b000, 1'b0, 5'd3, 32'h77, 32'd0, 32'd0, 32'd0);
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        check("flush_dropped", 32'(saw), 32'd0);

        // Reset arriving while both stages are stalled
        @(negedge clk);
        out_ready = 1'b0;
        drive(OPI, 3'b000, 1'b0, 5'd4, 32'h55, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_stall_wdata", out_wdata, 32'd0);
        check("rst_stall_alu_a", alu_a, 32'd0);
        check("rst_stall_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        check("rst_stall_discard", 32'(saw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
